// File: rtl/tinytpu_serial_host.sv
// Host-side master for the tinytpu bit-serial link: shifts x/y operand pairs out LSB first and
// reassembles the qualified z stream into result words. Optional watchdog: TINYTPU_HOST_TIMEOUT_EN.
module tinytpu_serial_host #(
  parameter int D_W   = 8,
  parameter int N     = 3,
  parameter int RES_W = 18
`ifdef TINYTPU_HOST_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 1024
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [D_W-1:0]   in_x,
  input  logic [D_W-1:0]   in_y,
  output logic             tpu_x,
  output logic             tpu_y,
  output logic             tpu_load_en,
  output logic             tpu_init,
  input  logic             tpu_z,
  input  logic             tpu_tx_ready,
  output logic             res_valid,
  output logic [RES_W-1:0] res_data,
  output logic             res_last,
  output logic             done,
  output logic             err_timeout
);

  localparam int MAXW = (D_W > RES_W) ? D_W : RES_W;
  localparam int BW   = $clog2(MAXW + 1);
  localparam int CW   = $clog2(N + 1);

  localparam logic [BW-1:0] TX_LAST  = BW'(D_W - 1);
  localparam logic [BW-1:0] RX_LAST  = BW'(RES_W - 1);
  localparam logic [CW-1:0] PAIR_ALL = CW'(N);
  localparam logic [CW-1:0] RES_FIN  = CW'(N - 1);

  typedef enum logic [2:0] {IDLE, INIT, SHIFT, WAIT_RDY, RECV} state_t;

  state_t           state_reg, state_next;
  logic [BW-1:0]    bit_cnt_reg, bit_cnt_next;
  logic [CW-1:0]    pair_cnt_reg, pair_cnt_next;
  logic [CW-1:0]    res_cnt_reg, res_cnt_next;
  logic [D_W-1:0]   x_sr_reg, x_sr_next;
  logic [D_W-1:0]   y_sr_reg, y_sr_next;
  logic [RES_W-1:0] z_sr_reg, z_sr_next;
  logic [RES_W-1:0] z_word;
  logic [RES_W-1:0] data_reg, data_next;
  logic             x_reg, x_next;
  logic             y_reg, y_next;
  logic             load_reg, load_next;
  logic             init_reg, init_next;
  logic             valid_reg, valid_next;
  logic             last_reg, last_next;
  logic             done_reg, done_next;
  logic             err_reg, err_next;
`ifdef TINYTPU_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0]    wd_reg, wd_next;
`endif

  // bit_cnt doubles as "bits still pending" while shifting, so zero also marks the last bit cycle
  assign in_ready    = (state_reg == SHIFT) && (bit_cnt_reg == '0) && (pair_cnt_reg != PAIR_ALL);
  assign busy        = (state_reg != IDLE);
  assign tpu_x       = x_reg;
  assign tpu_y       = y_reg;
  assign tpu_load_en = load_reg;
  assign tpu_init    = init_reg;
  assign res_valid   = valid_reg;
  assign res_data    = data_reg;
  assign res_last    = last_reg;
  assign done        = done_reg;
  assign err_timeout = err_reg;

  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    pair_cnt_next = pair_cnt_reg;
    res_cnt_next  = res_cnt_reg;
    x_sr_next     = x_sr_reg;
    y_sr_next     = y_sr_reg;
    z_sr_next     = z_sr_reg;
    data_next     = data_reg;
    x_next        = 1'b0;
    y_next        = 1'b0;
    load_next     = 1'b0;
    init_next     = 1'b0;
    valid_next    = 1'b0;
    last_next     = 1'b0;
    done_next     = 1'b0;
    err_next      = 1'b0;
`ifdef TINYTPU_HOST_TIMEOUT_EN
    wd_next       = wd_reg;
`endif
    z_word              = z_sr_reg;
    z_word[bit_cnt_reg] = tpu_z;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = INIT;
          init_next  = 1'b1;
        end
      end
      INIT: begin
        bit_cnt_next  = '0;
        pair_cnt_next = '0;
        res_cnt_next  = '0;
        z_sr_next     = '0;
`ifdef TINYTPU_HOST_TIMEOUT_EN
        wd_next       = '0;
`endif
        state_next    = SHIFT;
      end
      SHIFT: begin
        if (bit_cnt_reg != '0) begin
          x_next       = x_sr_reg[0];
          y_next       = y_sr_reg[0];
          load_next    = 1'b1;
          x_sr_next    = x_sr_reg >> 1;
          y_sr_next    = y_sr_reg >> 1;
          bit_cnt_next = bit_cnt_reg - 1'b1;
        end else if (in_valid && in_ready) begin
          x_next        = in_x[0];
          y_next        = in_y[0];
          load_next     = 1'b1;
          x_sr_next     = in_x >> 1;
          y_sr_next     = in_y >> 1;
          bit_cnt_next  = TX_LAST;
          pair_cnt_next = pair_cnt_reg + 1'b1;
        end else if (pair_cnt_reg == PAIR_ALL) begin
          state_next = WAIT_RDY;
        end
      end
      WAIT_RDY, RECV: begin
        if (tpu_tx_ready) begin
`ifdef TINYTPU_HOST_TIMEOUT_EN
          wd_next = '0;
`endif
          z_sr_next = z_word;
          if (bit_cnt_reg == RX_LAST) begin
            valid_next   = 1'b1;
            data_next    = z_word;
            bit_cnt_next = '0;
            res_cnt_next = res_cnt_reg + 1'b1;
            if (res_cnt_reg == RES_FIN) begin
              last_next  = 1'b1;
              done_next  = 1'b1;
              state_next = IDLE;
            end else begin
              state_next = WAIT_RDY;
            end
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
            state_next   = RECV;
          end
        end
`ifdef TINYTPU_HOST_TIMEOUT_EN
        // Partial word is simply dropped; the next INIT clears all receive state
        else if (wd_reg == WD_LAST) begin
          err_next     = 1'b1;
          bit_cnt_next = '0;
          wd_next      = '0;
          state_next   = IDLE;
        end else begin
          wd_next = wd_reg + 1'b1;
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= '0;
      pair_cnt_reg <= '0;
      res_cnt_reg  <= '0;
      x_sr_reg     <= '0;
      y_sr_reg     <= '0;
      z_sr_reg     <= '0;
      data_reg     <= '0;
      x_reg        <= 1'b0;
      y_reg        <= 1'b0;
      load_reg     <= 1'b0;
      init_reg     <= 1'b0;
      valid_reg    <= 1'b0;
      last_reg     <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
`ifdef TINYTPU_HOST_TIMEOUT_EN
      wd_reg       <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      pair_cnt_reg <= pair_cnt_next;
      res_cnt_reg  <= res_cnt_next;
      x_sr_reg     <= x_sr_next;
      y_sr_reg     <= y_sr_next;
      z_sr_reg     <= z_sr_next;
      data_reg     <= data_next;
      x_reg        <= x_next;
      y_reg        <= y_next;
      load_reg     <= load_next;
      init_reg     <= init_next;
      valid_reg    <= valid_next;
      last_reg     <= last_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
`ifdef TINYTPU_HOST_TIMEOUT_EN
      wd_reg       <= wd_next;
`endif
    end
  end

endmodule

// File: tb/tb_tinytpu_serial_host.sv
// Directed bench for tinytpu_serial_host: framing, serial operand order, result assembly,
// reset abort, start-while-busy and (with TINYTPU_HOST_TIMEOUT_EN) the watchdog.
module tb_tinytpu_serial_host;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_x = '0;
  logic [7:0]  in_y = '0;
  logic        tpu_x, tpu_y, tpu_load_en, tpu_init;
  logic        tpu_z = 1'b0;
  logic        tpu_tx_ready = 1'b0;
  logic        res_valid;
  logic [17:0] res_data;
  logic        res_last, done, err_timeout;

  int tests = 0;
  int fails = 0;

  tinytpu_serial_host #(
    .D_W(8), .N(3), .RES_W(18)
`ifdef TINYTPU_HOST_TIMEOUT_EN
    , .TIMEOUT_CYC(16)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .tpu_x(tpu_x), .tpu_y(tpu_y), .tpu_load_en(tpu_load_en), .tpu_init(tpu_init),
    .tpu_z(tpu_z), .tpu_tx_ready(tpu_tx_ready),
    .res_valid(res_valid), .res_data(res_data), .res_last(res_last),
    .done(done), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "global timeout");
  end

  logic [27:0] out_vec;
  assign out_vec = {busy, in_ready, tpu_x, tpu_y, tpu_load_en, tpu_init,
                    res_valid, res_last, done, err_timeout, res_data};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", tag, got);
    end
  endtask

  // Negedge monitor: everything the DUT emits is recorded here
  int cyc = 0, loads = 0, inits = 0, dones = 0, errs = 0, first_load = 0, last_load = 0;
  logic        xq[$];
  logic        yq[$];
  logic [17:0] rq[$];
  logic        lq[$];
  logic        dq[$];
  int          hc = 0;

  always @(negedge clk) begin
    cyc++;
    if (tpu_load_en === 1'b1) begin
      if (loads == 0) first_load = cyc;
      last_load = cyc;
      loads++;
      xq.push_back(tpu_x);
      yq.push_back(tpu_y);
    end
    if (tpu_init === 1'b1) inits++;
    if (res_valid === 1'b1) begin
      rq.push_back(res_data);
      lq.push_back(res_last);
      dq.push_back(done);
    end
    if (done === 1'b1) dones++;
    if (err_timeout === 1'b1) errs++;
  end

  task automatic clear_mon();
    #1;
    loads = 0; inits = 0; dones = 0; errs = 0; first_load = 0; last_load = 0;
    xq.delete(); yq.delete(); rq.delete(); lq.delete(); dq.delete();
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic send_pair(input logic [7:0] x, input logic [7:0] y, input int gap);
    in_valid = 1'b0;
    wait_ready();
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
    in_x = x;
    in_y = y;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_shift_end();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(loads == 24 && tpu_load_en == 1'b0) && n < 300);
    if (n >= 300) check("shift_end_timeout", 32'(loads), 32'd24);
  endtask

  // xs/ys hold pair0 in bits [7:0]; gap idle cycles are inserted before pair 1
  task automatic run_frame(input logic [23:0] xs, input logic [23:0] ys, input int gap,
                           input bit poke, input string tag);
    logic [7:0] xb, yb;
    logic [7:0] seq;
    clear_mon();
    pulse_start();
    for (int p = 0; p < 3; p++) begin
      send_pair(xs[p*8 +: 8], ys[p*8 +: 8], (p == 1) ? gap : 0);
      if (p == 0 && poke) begin
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end
    end
    wait_shift_end();
    check({tag, "_init_pulses"}, 32'(inits), 32'd1);
    check({tag, "_load_cycles"}, 32'(loads), 32'd24);
    check({tag, "_load_gaps"}, 32'(last_load - first_load + 1 - loads), 32'(gap));
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 8; k++) begin
        xb[k] = xq[p*8 + k];
        yb[k] = yq[p*8 + k];
      end
      check($sformatf("%s_x%0d", tag, p), 32'(xb), 32'(xs[p*8 +: 8]));
      check($sformatf("%s_y%0d", tag, p), 32'(yb), 32'(ys[p*8 +: 8]));
    end
    for (int k = 0; k < 8; k++) seq[7-k] = xq[k];
    if (xs[7:0] == 8'h01) check({tag, "_x_first_seq"}, 32'(seq), 32'h80);
  endtask

  // Results go out LSB first; every third cycle is a tx_ready hole
  task automatic send_results(input logic [53:0] words);
    for (int w = 0; w < 3; w++) begin
      int k = 0;
      while (k < 18) begin
        @(negedge clk);
        hc++;
        if (hc % 3 == 0) begin
          tpu_tx_ready = 1'b0;
          tpu_z = 1'b0;
        end else begin
          tpu_tx_ready = 1'b1;
          tpu_z = words[w*18 + k];
          k++;
        end
      end
    end
    @(negedge clk);
    tpu_tx_ready = 1'b0;
    tpu_z = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_results(input string tag);
    check({tag, "_res_count"}, 32'(rq.size()), 32'd3);
    check({tag, "_res0"}, 32'(rq[0]), 32'h00001);
    check({tag, "_res1"}, 32'(rq[1]), 32'h2AAAA);
    check({tag, "_res2"}, 32'(rq[2]), 32'h3FFFF);
    check({tag, "_res_last_flags"}, 32'({lq[2], lq[1], lq[0]}), 32'b100);
    check({tag, "_done_flags"}, 32'({dq[2], dq[1], dq[0]}), 32'b100);
    check({tag, "_done_pulses"}, 32'(dones), 32'd1);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  localparam logic [53:0] RES_WORDS = {18'h3FFFF, 18'h2AAAA, 18'h00001};

  initial begin
    #23;
    check("reset_outputs", 32'(out_vec), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // back-to-back pairs (0x01,0x80),(0xA5,0x5A),(0xFF,0x00)
    run_frame({8'hFF, 8'hA5, 8'h01}, {8'h00, 8'h5A, 8'h80}, 0, 1'b0, "f1");
`ifndef TINYTPU_HOST_TIMEOUT_EN
    repeat (40) @(negedge clk);
    check("f1_still_busy_no_wd", 32'(busy), 32'd1);
    check("f1_no_err", 32'(errs), 32'd0);
`endif
    send_results(RES_WORDS);
    check_results("f1");

    // 5-cycle operand gap, plus start poked while busy
    run_frame({8'h80, 8'h12, 8'h3C}, {8'h01, 8'h34, 8'hC3}, 5, 1'b1, "f2");
    send_results(RES_WORDS);
    check_results("f2");

    // reset mid-SHIFT aborts the frame
    clear_mon();
    pulse_start();
    send_pair(8'h5A, 8'hA5, 0);
    repeat (3) @(negedge clk);
    check("pre_reset_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1 check("reset_mid_async", 32'(out_vec), 32'd0);
    @(negedge clk);
    check("reset_mid_next", 32'(out_vec), 32'd0);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("post_reset_no_res", 32'(rq.size()), 32'd0);
    check("post_reset_no_done", 32'(dones), 32'd0);
    check("post_reset_idle", 32'(busy), 32'd0);

    run_frame({8'hFF, 8'hA5, 8'h01}, {8'h00, 8'h5A, 8'h80}, 0, 1'b0, "f3");
    send_results(RES_WORDS);
    check_results("f3");

`ifdef TINYTPU_HOST_TIMEOUT_EN
    begin
      int n = 0;
      run_frame({8'h0F, 8'hF0, 8'h33}, {8'hCC, 8'h55, 8'hAA}, 0, 1'b0, "f4");
      while (err_timeout !== 1'b1 && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("wd_cycles", 32'(n), 32'd16);
      check("wd_busy", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      check("wd_err_pulses", 32'(errs), 32'd1);
      check("wd_no_done", 32'(dones), 32'd0);
      check("wd_no_res", 32'(rq.size()), 32'd0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
